// File: rtl/four_bit_cla_pkg.sv
// Shared definitions for the 4-bit carry-lookahead adder slice and the
// second-level lookahead unit that consumes its group propagate/generate.
package four_bit_cla_pkg;

    localparam int CLA_W = 4;

    // Group propagate/generate pair handed to the next lookahead level.
    typedef struct packed {
        logic pg;
        logic gg;
    } cla_grp_t;

endpackage

// File: rtl/four_bit_cla_logic.sv
// Purely combinational lookahead core: bit P/G, parallel carries, sum and
// group P/G. Every carry is a flat sum of products over the bit P/G terms,
// so the all-propagate case never ripples.
import four_bit_cla_pkg::*;

module cla_logic (
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             cin,
    output logic [CLA_W-1:0] sum,
    output logic             c3,
    output logic             c4,
    output cla_grp_t         grp
);

    logic [CLA_W-1:0] p;
    logic [CLA_W-1:0] g;
    logic [CLA_W:0]   c;

    // Bit propagate/generate, flat two-level carries, sum and group terms.
    always_comb begin
        p = a ^ b;
        g = a & b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c[0]);

        sum = p ^ c[CLA_W-1:0];
        c3  = c[3];
        c4  = c[4];

        // Group generate deliberately excludes cin so the next level can
        // combine slices without waiting on this slice's carry-in.
        grp.pg = p[3] & p[2] & p[1] & p[0];
        grp.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/four_bit_cla.sv
// Registered 4-bit carry-lookahead adder slice: one-cycle latency, a new
// operation every cycle, all outputs cleared asynchronously by rst_n.
import four_bit_cla_pkg::*;

module four_bit_cla (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CLA_W-1:0] A,
    input  logic [CLA_W-1:0] B,
    input  logic             cin,
    output logic [CLA_W-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             pg,
    output logic             gg
);

    logic [CLA_W-1:0] sum_c;
    logic             c3_c;
    logic             c4_c;
    cla_grp_t         grp_c;

    cla_logic u_cla_logic (
        .a   (A),
        .b   (B),
        .cin (cin),
        .sum (sum_c),
        .c3  (c3_c),
        .c4  (c4_c),
        .grp (grp_c)
    );

    // Output register; reset drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            pg   <= 1'b0;
            gg   <= 1'b0;
        end else begin
            sum  <= sum_c;
            cout <= c4_c;
            ovf  <= c4_c ^ c3_c;
            pg   <= grp_c.pg;
            gg   <= grp_c.gg;
        end
    end

endmodule

// File: tb/tb_four_bit_cla.sv
// Scoreboard bench for four_bit_cla: stimulus pushes expected results,
// a monitor pops and compares one cycle after each issued operation.
module tb_four_bit_cla;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
        logic       pg;
        logic       gg;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       pg;
    logic       gg;

    int   checks;
    int   errors;
    logic issue;
    exp_t exp_q[$];

    four_bit_cla dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .pg    (pg),
        .gg    (gg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference built from arithmetic, not lookahead equations.
    function automatic exp_t ref_model(input logic [3:0] a, input logic [3:0] b, input logic c);
        exp_t       e;
        logic [4:0] s;
        logic [4:0] s0;
        s      = {1'b0, a} + {1'b0, b} + {4'b0, c};
        s0     = {1'b0, a} + {1'b0, b};
        e.sum  = s[3:0];
        e.cout = s[4];
        e.ovf  = (a[3] == b[3]) && (s[3] != a[3]);
        e.pg   = ((a ^ b) == 4'hF);
        e.gg   = s0[4];
        return e;
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c, input exp_t e);
        A   = a;
        B   = b;
        cin = c;
        exp_q.push_back(e);
        issue = 1'b1;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({sum, cout, ovf, pg, gg} !== 8'h00) begin
            errors++;
            $display("FAIL %s: got sum=%b cout=%b ovf=%b pg=%b gg=%b, want all zero",
                     name, sum, cout, ovf, pg, gg);
        end
    endtask

    // Monitor: an operation issued before an edge with rst_n high is
    // compared against the head of the scoreboard just after that edge.
    initial begin
        logic took;
        logic took_cin;
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            took     = issue && rst_n;
            took_cin = cin;
            #1;
            if (took) begin
                got = '{sum, cout, ovf, pg, gg};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: got result %h with nothing expected", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL result: got sum=%b cout=%b ovf=%b pg=%b gg=%b, want sum=%b cout=%b ovf=%b pg=%b gg=%b",
                                 sum, cout, ovf, pg, gg, e.sum, e.cout, e.ovf, e.pg, e.gg);
                    end
                end
                checks++;
                if (cout !== (gg | (pg & took_cin))) begin
                    errors++;
                    $display("FAIL invariant: got cout=%b, want gg|(pg&cin)=%b", cout, gg | (pg & took_cin));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want bench to finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // Directed vectors with hand-computed results: {sum, cout, ovf, pg, gg}.
    localparam exp_t E_FFF1 = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam exp_t E_0001 = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t E_0000 = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t E_3C0  = '{4'b1111, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam exp_t E_3C1  = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam exp_t E_AA0  = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam exp_t E_AA1  = '{4'b0101, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam exp_t E_5D0  = '{4'b0010, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic run_six();
        @(negedge clk); drive(4'b0000, 4'b0000, 1'b1, E_0001);
        @(negedge clk); drive(4'b0000, 4'b0000, 1'b0, E_0000);
        @(negedge clk); drive(4'b0011, 4'b1100, 1'b0, E_3C0);
        @(negedge clk); drive(4'b0011, 4'b1100, 1'b1, E_3C1);
        @(negedge clk); drive(4'b1010, 4'b1010, 1'b0, E_AA0);
        @(negedge clk); drive(4'b1010, 4'b1010, 1'b1, E_AA1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        issue  = 1'b0;
        rst_n  = 1'b0;
        A      = 4'b1111;
        B      = 4'b1111;
        cin    = 1'b1;
        #2;
        check_zero("reset_initial");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");

        // Release and capture the all-ones operands on the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1, E_FFF1);

        // Back-to-back pipeline of the directed set.
        run_six();
        @(negedge clk); drive(4'b0101, 4'b1101, 1'b0, E_5D0);

        // Mid-stream reset: clears outputs between edges, then resumes.
        @(negedge clk); drive(4'b0011, 4'b1100, 1'b0, E_3C0);
        @(negedge clk); drive(4'b1010, 4'b1010, 1'b0, E_AA0);
        @(negedge clk);
        issue = 1'b0;
        A     = 4'b1111;
        B     = 4'b1111;
        cin   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async_mid");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_mid_held");
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0101, 4'b1101, 1'b0, E_5D0);
        @(negedge clk); drive(4'b1010, 4'b1010, 1'b1, E_AA1);
        @(negedge clk); drive(4'b0011, 4'b1100, 1'b1, E_3C1);

        // Exhaustive sweep against the arithmetic reference.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            @(negedge clk);
            drive(v[8:5], v[4:1], v[0], ref_model(v[8:5], v[4:1], v[0]));
        end

        @(negedge clk);
        issue = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results still pending, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
